// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon permutation sequencer.
//  - State width, round schedule length and the x0..x4 word offsets
//    inside the 320-bit state {x0,x1,x2,x3,x4} (x0 in the MSBs).
//  - FSM state type for the permutation controller.
//  - Round-constant and 64-bit rotate helpers.
package ascon_pkg;

  localparam int unsigned ASCON_STATE_W    = 320;
  localparam int unsigned ASCON_WORD_W     = 64;
  localparam int unsigned ASCON_MAX_ROUNDS = 12;

  // LSB offset of each word: index 0 = x0 ... index 4 = x4
  localparam int unsigned X_LSB [5] = '{256, 192, 128, 64, 0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } perm_state_e;

  // c = 0xF0 - idx*0x0F, 8-bit wrap
  function automatic logic [7:0] rc(input logic [7:0] idx);
    return 8'hF0 - (idx * 8'h0F);
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned r);
    return (x >> r) | (x << (64 - r));
  endfunction

endpackage

// File: rtl/ascon_perm_ctrl_if.sv
// Handshake/data bundle between the ASCON mode controller (master) and the
// permutation sequencer (slave).
//  start_i      request a permutation (taken when ready_o=1)
//  num_rounds_i n for p^n, sampled with start_i
//  state_i      input state, sampled with start_i
//  ready_o      sequencer can accept start_i
//  busy_o       permutation in progress
//  done_o       one-cycle pulse, state_o holds the result
//  state_o      registered state
//  round_idx_o  round index applied this cycle, 0 when not running
interface ascon_perm_ctrl_if
  import ascon_pkg::*;
#(
  parameter int unsigned ROUND_W = 4
);
  logic                     start_i;
  logic [ROUND_W-1:0]       num_rounds_i;
  logic [ASCON_STATE_W-1:0] state_i;
  logic                     ready_o;
  logic                     busy_o;
  logic                     done_o;
  logic [ASCON_STATE_W-1:0] state_o;
  logic [ROUND_W-1:0]       round_idx_o;

  modport master (
    output start_i, num_rounds_i, state_i,
    input  ready_o, busy_o, done_o, state_o, round_idx_o
  );

  modport slave (
    input  start_i, num_rounds_i, state_i,
    output ready_o, busy_o, done_o, state_o, round_idx_o
  );
endinterface

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition into x2[7:0], bitsliced
// 5-bit S-box layer across all 64 columns, then per-word linear diffusion.
//  state_i      320-bit state before the round
//  round_idx_i  round index selecting the constant
//  state_o      320-bit state after the round
module ascon_round
  import ascon_pkg::*;
#(
  parameter int unsigned ROUND_W = 4
) (
  input  logic [ASCON_STATE_W-1:0] state_i,
  input  logic [ROUND_W-1:0]       round_idx_i,
  output logic [ASCON_STATE_W-1:0] state_o
);

  logic [63:0] a [5];
  logic [63:0] t [5];
  logic [63:0] b [5];
  logic [63:0] l [5];

  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      a[i] = state_i[X_LSB[i] +: ASCON_WORD_W];
    end
    a[2][7:0] = a[2][7:0] ^ rc(8'(round_idx_i));

    // S-box: input mixing, chi-like nonlinear step, output mixing
    a[0] = a[0] ^ a[4];
    a[4] = a[4] ^ a[3];
    a[2] = a[2] ^ a[1];
    for (int unsigned i = 0; i < 5; i++) begin
      t[i] = ~a[i] & a[(i + 1) % 5];
    end
    for (int unsigned i = 0; i < 5; i++) begin
      b[i] = a[i] ^ t[(i + 1) % 5];
    end
    b[1] = b[1] ^ b[0];
    b[0] = b[0] ^ b[4];
    b[3] = b[3] ^ b[2];
    b[2] = ~b[2];

    l[0] = b[0] ^ ror64(b[0], 19) ^ ror64(b[0], 28);
    l[1] = b[1] ^ ror64(b[1], 61) ^ ror64(b[1], 39);
    l[2] = b[2] ^ ror64(b[2], 1)  ^ ror64(b[2], 6);
    l[3] = b[3] ^ ror64(b[3], 10) ^ ror64(b[3], 17);
    l[4] = b[4] ^ ror64(b[4], 7)  ^ ror64(b[4], 41);

    state_o = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      state_o[X_LSB[i] +: ASCON_WORD_W] = l[i];
    end
  end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Ascon permutation sequencer: applies p^n one round per clock using
// round indices MAX_ROUNDS-n .. MAX_ROUNDS-1.
//  clk    rising-edge clock
//  rst_n  asynchronous active-low reset
//  bus    slave side of ascon_perm_ctrl_if (start/ready/busy/done handshake,
//         round count, input/output state, round index trace)
// Holds the FSM, round counter, rounds-left counter and state register; the
// round arithmetic lives in ascon_round.
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = ASCON_MAX_ROUNDS,
  parameter int unsigned ROUND_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ascon_perm_ctrl_if.slave    bus
);

  perm_state_e              fsm_q, fsm_d;
  logic [ASCON_STATE_W-1:0] state_q, state_d;
  logic [ROUND_W-1:0]       ctr_q, ctr_d;
  logic [ROUND_W-1:0]       left_q, left_d;
  logic [ROUND_W-1:0]       n_clamped;
  logic [ASCON_STATE_W-1:0] round_out;

  ascon_round #(
    .ROUND_W (ROUND_W)
  ) u_round (
    .state_i     (state_q),
    .round_idx_i (ctr_q),
    .state_o     (round_out)
  );

  always_comb begin
    n_clamped = bus.num_rounds_i;
    if (32'(bus.num_rounds_i) > MAX_ROUNDS) begin
      n_clamped = ROUND_W'(MAX_ROUNDS);
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    ctr_d   = ctr_q;
    left_d  = left_q;
    unique case (fsm_q)
      // DONE shares the accept path with IDLE so a start in the done cycle
      // goes straight back to LOAD.
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          state_d = bus.state_i;
          ctr_d   = ROUND_W'(MAX_ROUNDS) - n_clamped;
          left_d  = n_clamped;
          fsm_d   = ST_LOAD;
        end else begin
          fsm_d   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        fsm_d = (left_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        state_d = round_out;
        ctr_d   = ctr_q + 1'b1;
        left_d  = left_q - 1'b1;
        if (left_q == ROUND_W'(1)) begin
          fsm_d = ST_DONE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      ctr_q   <= '0;
      left_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ctr_q   <= ctr_d;
      left_q  <= left_d;
    end
  end

  assign bus.ready_o     = (fsm_q == ST_IDLE) || (fsm_q == ST_DONE);
  assign bus.busy_o      = (fsm_q == ST_LOAD) || (fsm_q == ST_RUN);
  assign bus.done_o      = (fsm_q == ST_DONE);
  assign bus.state_o     = state_q;
  assign bus.round_idx_o = (fsm_q == ST_RUN) ? ctr_q : '0;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
module tb_ascon_perm_ctrl;
  import ascon_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascon_perm_ctrl_if #(.ROUND_W(4)) bus ();

  ascon_perm_ctrl #(
    .MAX_ROUNDS (12),
    .ROUND_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Ascon S-box as a plain 32-entry table, input {x0,x1,x2,x3,x4} with x0 as MSB
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
  localparam int ROT2 [5] = '{28, 39, 6, 17, 41};

  typedef struct packed {
    logic         ready;
    logic         busy;
    logic         done;
    logic [3:0]   idx;
    logic [319:0] st;
  } exp_t;

  localparam exp_t RESET_EXP = '{ready:1'b1, busy:1'b0, done:1'b0, idx:4'd0, st:'0};

  exp_t cur = RESET_EXP;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] m_rc(input int idx);
    return 8'((240 - idx * 15) & 255);
  endfunction

  function automatic logic [63:0] m_rot(input logic [63:0] x, input int r);
    logic [127:0] d;
    d = {x, x} >> r;
    return d[63:0];
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input int idx);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v, o;
    logic [319:0] r;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    x[2][7:0] = x[2][7:0] ^ m_rc(idx);
    for (int bt = 0; bt < 64; bt++) begin
      v = {x[0][bt], x[1][bt], x[2][bt], x[3][bt], x[4][bt]};
      o = SBOX[v];
      for (int i = 0; i < 5; i++) y[i][bt] = o[4 - i];
    end
    for (int i = 0; i < 5; i++)
      r[319 - 64*i -: 64] = y[i] ^ m_rot(y[i], ROT1[i]) ^ m_rot(y[i], ROT2[i]);
    return r;
  endfunction

  function automatic int m_clamp(input int n);
    return (n > 12) ? 12 : n;
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input int n);
    int nc;
    nc = m_clamp(n);
    for (int k = 0; k < nc; k++) s = m_round(s, 12 - nc + k);
    return s;
  endfunction

  // expected per-cycle outputs for one accepted permutation
  function automatic void build(input int n, input logic [319:0] st);
    int nc;
    logic [319:0] s;
    nc = m_clamp(n);
    s  = st;
    q.push_back('{ready:1'b0, busy:1'b1, done:1'b0, idx:4'd0, st:s});
    for (int k = 0; k < nc; k++) begin
      q.push_back('{ready:1'b0, busy:1'b1, done:1'b0, idx:4'(12 - nc + k), st:s});
      s = m_round(s, 12 - nc + k);
    end
    q.push_back('{ready:1'b1, busy:1'b0, done:1'b1, idx:4'd0, st:s});
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    exp_t nxt;
    if (!rst_n) begin
      q.delete();
      cur <= RESET_EXP;
    end else begin
      if (bus.start_i && cur.ready) build(int'(bus.num_rounds_i), bus.state_i);
      if (q.size() > 0) begin
        nxt = q.pop_front();
      end else begin
        nxt       = cur;
        nxt.ready = 1'b1;
        nxt.busy  = 1'b0;
        nxt.done  = 1'b0;
        nxt.idx   = 4'd0;
      end
      cur <= nxt;
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("ready_o", 320'(bus.ready_o), 320'(cur.ready));
    chk("busy_o", 320'(bus.busy_o), 320'(cur.busy));
    chk("done_o", 320'(bus.done_o), 320'(cur.done));
    chk("round_idx_o", 320'(bus.round_idx_o), 320'(cur.idx));
    chk("state_o", bus.state_o, cur.st);
    if (bus.done_o === 1'b1) done_seen++;
  end

  // ---------------- stimulus ----------------
  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic start_req(input logic [3:0] n, input logic [319:0] st, input bit hold);
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.num_rounds_i = n;
    bus.state_i      = st;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      bus.start_i      = 1'b0;
      bus.num_rounds_i = 4'($urandom);
      bus.state_i      = rand_state();
    end
  endtask

  // called at the negedge of cycle c0 after acceptance; lat=-1 on timeout
  task automatic wait_done(input int c0, output int lat);
    lat = -1;
    for (int c = c0; c <= 60; c++) begin
      if (bus.done_o === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int lat, d0, n;
    logic [319:0] st, r0, want;
    logic [95:0] sched;

    bus.start_i      = 1'b0;
    bus.num_rounds_i = '0;
    bus.state_i      = '0;

    // model pins: constant schedule and one round on the zero state at idx 0
    for (int i = 0; i < 12; i++) sched[95 - 8*i -: 8] = m_rc(i);
    chk("pin_rc_schedule", 320'(sched), 320'(96'hF0E1D2C3B4A5968778695A4B));
    r0 = m_round('0, 0);
    chk("pin_round0_x0", 320'(r0[319:256]), 320'(64'h001E0F00000000F0));
    chk("pin_round0_x1", 320'(r0[255:192]), 320'(64'h00000001E0000770));
    chk("pin_round0_x2", 320'(r0[191:128]), 320'(64'h3FFFFFFFFFFFFF74));
    chk("pin_round0_x3", 320'(r0[127:64]),  320'(64'h3C780000000000F0));
    chk("pin_round0_x4", 320'(r0[63:0]),    320'(64'h0));

    // 1. reset values, then idle
    #1;
    chk("rst_ready", 320'(bus.ready_o), 320'(1));
    chk("rst_busy", 320'(bus.busy_o), 320'(0));
    chk("rst_done", 320'(bus.done_o), 320'(0));
    chk("rst_state", bus.state_o, '0);
    #21 rst_n = 1'b1;
    d0 = done_seen;
    repeat (20) @(negedge clk);
    chk("idle_no_done", 320'(done_seen - d0), 320'(0));
    chk("idle_ready", 320'(bus.ready_o), 320'(1));

    // 2. p^12 on zero state
    start_req(4'd12, '0, 1'b0);
    wait_done(1, lat);
    chk("lat_p12", 320'(lat), 320'(14));
    chk("res_p12", bus.state_o, m_perm('0, 12));

    // 3. p^6 and p^8
    st = rand_state();
    start_req(4'd6, st, 1'b0);
    wait_done(1, lat);
    chk("lat_p6", 320'(lat), 320'(8));
    chk("res_p6", bus.state_o, m_perm(st, 6));
    st = rand_state();
    start_req(4'd8, st, 1'b0);
    wait_done(1, lat);
    chk("lat_p8", 320'(lat), 320'(10));
    chk("res_p8", bus.state_o, m_perm(st, 8));

    // 4. edge n values
    st = rand_state();
    start_req(4'd0, st, 1'b0);
    wait_done(1, lat);
    chk("lat_p0", 320'(lat), 320'(2));
    chk("res_p0", bus.state_o, st);
    start_req(4'd15, '0, 1'b0);
    wait_done(1, lat);
    chk("lat_n15", 320'(lat), 320'(14));
    chk("res_n15", bus.state_o, m_perm('0, 12));

    // 5a. start pulsed during RUN is ignored
    st = rand_state();
    start_req(4'd8, st, 1'b0);
    repeat (3) @(negedge clk);
    bus.start_i      = 1'b1;
    bus.num_rounds_i = 4'd2;
    bus.state_i      = rand_state();
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done(5, lat);
    chk("lat_ignore", 320'(lat), 320'(10));
    chk("res_ignore", bus.state_o, m_perm(st, 8));

    // 5b. start held into the done cycle: back-to-back
    st = rand_state();
    start_req(4'd12, st, 1'b1);
    wait_done(1, lat);
    chk("lat_b2b_first", 320'(lat), 320'(14));
    want = m_perm(st, 12);
    chk("res_b2b_first", bus.state_o, want);
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done(1, lat);
    chk("b2b_spacing", 320'(lat), 320'(14));
    chk("res_b2b_second", bus.state_o, want);

    // 6. reset abort during RUN cycle 5
    start_req(4'd12, rand_state(), 1'b0);
    repeat (5) @(negedge clk);
    d0 = done_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 320'(bus.ready_o), 320'(1));
    chk("abort_busy", 320'(bus.busy_o), 320'(0));
    chk("abort_idx", 320'(bus.round_idx_o), 320'(0));
    chk("abort_state", bus.state_o, '0);
    #9 rst_n = 1'b1;
    repeat (16) @(negedge clk);
    chk("abort_no_done", 320'(done_seen - d0), 320'(0));
    st = rand_state();
    start_req(4'd12, st, 1'b0);
    wait_done(1, lat);
    chk("lat_after_abort", 320'(lat), 320'(14));
    chk("res_after_abort", bus.state_o, m_perm(st, 12));

    // randomized transactions
    for (int it = 0; it < 25; it++) begin
      n  = int'($urandom_range(0, 15));
      st = rand_state();
      start_req(4'(n), st, 1'b0);
      wait_done(1, lat);
      chk("lat_rand", 320'(lat), 320'(m_clamp(n) + 2));
      chk("res_rand", bus.state_o, m_perm(st, n));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
